// File: rtl/vreg_wb_sequencer.sv
// Write-back sequencer: queues destination register-group descriptors and expands result beats
// into per-register file writes, flagging group completion and results with no destination.
module vreg_wb_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_vlmul,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  grp_done,
  output logic                  orphan_err,
  output logic                  idle
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  // Group size reaches 8 registers, so never narrower than 4 bits.
  localparam int unsigned CNT_W = (ADDR_WIDTH + 1 > 4) ? ADDR_WIDTH + 1 : 4;

  logic [ADDR_WIDTH-1:0] base_mem [QUEUE_DEPTH];
  logic [CNT_W-1:0]      cnt_mem  [QUEUE_DEPTH];

  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [OCC_W-1:0]      occ;
  logic [CNT_W-1:0]      beat_cnt;

  logic [ADDR_WIDTH-1:0] push_base;
  logic [CNT_W-1:0]      push_cnt;
  logic [ADDR_WIDTH-1:0] head_base;
  logic [CNT_W-1:0]      head_cnt;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  accept;
  logic                  pop;

  // Descriptor decode: integer LMUL scales the group address, fractional LMUL is a single register.
  always_comb begin
    push_base = req_addr;
    push_cnt  = CNT_W'(1);
    if (!req_vlmul[2]) begin
      push_base = ADDR_WIDTH'(req_addr << req_vlmul[1:0]);
      push_cnt  = CNT_W'(CNT_W'(1) << req_vlmul[1:0]);
    end
  end

  assign head_base = base_mem[rd_ptr];
  assign head_cnt  = cnt_mem[rd_ptr];
  assign empty     = (occ == OCC_W'(0));
  assign full      = (occ == OCC_W'(QUEUE_DEPTH));
  assign req_ready = ~full;
  assign push      = req_valid & ~full;
  assign accept    = res_valid & ~empty;
  assign pop       = accept & (beat_cnt == CNT_W'(head_cnt - CNT_W'(1)));
  assign idle      = empty & ~wr_en;

  // Descriptor storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      base_mem[wr_ptr] <= push_base;
      cnt_mem[wr_ptr]  <= push_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      beat_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (accept) beat_cnt <= pop ? CNT_W'(0) : beat_cnt + CNT_W'(1);
    end
  end

  // Register-file write port, one cycle behind the accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      grp_done   <= 1'b0;
      orphan_err <= 1'b0;
    end else begin
      wr_en      <= accept;
      grp_done   <= pop;
      orphan_err <= res_valid & empty;
      if (accept) begin
        wr_addr <= ADDR_WIDTH'(head_base + ADDR_WIDTH'(beat_cnt));
        wr_data <= res_data;
      end
    end
  end

endmodule

// File: tb/tb_vreg_wb_sequencer.sv
// Directed-vector bench for vreg_wb_sequencer: per-cycle stimulus with expected write-port state.
module tb_vreg_wb_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_vlmul;
  logic [4:0]  req_addr;
  logic        res_valid;
  logic [63:0] res_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        grp_done;
  logic        orphan_err;
  logic        idle;

  int n_cmp;
  int n_bad;

  vreg_wb_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vlmul(req_vlmul), .req_addr(req_addr),
    .res_valid(res_valid), .res_data(res_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .grp_done(grp_done), .orphan_err(orphan_err), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [2:0]  vl;
    logic [4:0]  ad;
    logic        sv;
    logic [63:0] sd;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        gd;
    logic        oe;
    logic        idl;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rv, logic [2:0] vl, logic [4:0] ad, logic sv, logic [63:0] sd,
                              logic we, logic [4:0] wa, logic gd, logic oe, logic idl, logic rdy);
    vec_t v;
    v.rv = rv; v.vl = vl; v.ad = ad; v.sv = sv; v.sd = sd;
    v.we = we; v.wa = wa; v.wd = sd; v.gd = gd; v.oe = oe; v.idl = idl; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called at negedge), then check registered outputs just after the edge.
  task automatic apply(input vec_t v, input int idx);
    req_valid = v.rv; req_vlmul = v.vl; req_addr = v.ad;
    res_valid = v.sv; res_data  = v.sd;
    @(posedge clk);
    #1;
    chk("wr_en", idx, 64'(wr_en), 64'(v.we));
    if (v.we) begin
      chk("wr_addr", idx, 64'(wr_addr), 64'(v.wa));
      chk("wr_data", idx, wr_data, v.wd);
    end
    chk("grp_done", idx, 64'(grp_done), 64'(v.gd));
    chk("orphan_err", idx, 64'(orphan_err), 64'(v.oe));
    chk("idle", idx, 64'(idle), 64'(v.idl));
    chk("req_ready", idx, 64'(req_ready), 64'(v.rdy));
    @(negedge clk);
  endtask

  task automatic chk_reset(input int idx);
    chk("rst_wr_en", idx, 64'(wr_en), 64'd0);
    chk("rst_grp_done", idx, 64'(grp_done), 64'd0);
    chk("rst_orphan", idx, 64'(orphan_err), 64'd0);
    chk("rst_idle", idx, 64'(idle), 64'd1);
    chk("rst_ready", idx, 64'(req_ready), 64'd1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0;
    req_valid = 1'b0; req_vlmul = 3'd0; req_addr = 5'd0;
    res_valid = 1'b0; res_data = 64'd0;

    // Args: rv vl ad sv sd | we wa gd oe idle rdy
    // LMUL4 group at addr 3 -> regs 12..15
    vecs.push_back(mk(1, 3'd2, 5'd3, 0, 64'h0,                  0, 5'd0,  0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'hD0D0_0000_0000_0000, 1, 5'd12, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'hD1D1_0000_0000_0001, 1, 5'd13, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'hD2D2_0000_0000_0002, 1, 5'd14, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'hD3D3_0000_0000_0003, 1, 5'd15, 1, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 0, 64'h0,                  0, 5'd0,  0, 0, 1, 1));
    // Fractional LMUL: single register at addr 7
    vecs.push_back(mk(1, 3'd5, 5'd7, 0, 64'h0,                  0, 5'd0,  0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'h7777_AAAA_5555_0007, 1, 5'd7,  1, 0, 0, 1));
    // LMUL8 at addr 5 -> base 40 mod 32 = 8, regs 8..15
    vecs.push_back(mk(1, 3'd3, 5'd5, 0, 64'h0,                  0, 5'd0,  0, 0, 0, 1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'hB000_0000_0000_0000 + 64'(i),
                        1, 5'(8 + i), (i == 7), 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 0, 64'h0,                  0, 5'd0,  0, 0, 1, 1));
    // Orphan with empty FIFO, orphan in the push cycle, then a real beat for the pushed group
    vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'hEEEE,               0, 5'd0,  0, 1, 1, 1));
    vecs.push_back(mk(1, 3'd0, 5'd9, 1, 64'hEEEF,               0, 5'd0,  0, 1, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'h9999_0000_0000_0009, 1, 5'd9,  1, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 0, 64'h0,                  0, 5'd0,  0, 0, 1, 1));
    // Fill FIFO with four single-register groups, hold a fifth while full
    vecs.push_back(mk(1, 3'd0, 5'd1, 0, 64'h0,                  0, 5'd0,  0, 0, 0, 1));
    vecs.push_back(mk(1, 3'd0, 5'd2, 0, 64'h0,                  0, 5'd0,  0, 0, 0, 1));
    vecs.push_back(mk(1, 3'd0, 5'd3, 0, 64'h0,                  0, 5'd0,  0, 0, 0, 1));
    vecs.push_back(mk(1, 3'd0, 5'd4, 0, 64'h0,                  0, 5'd0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 3'd0, 5'd5, 1, 64'hF1,                 1, 5'd1,  1, 0, 0, 1));
    vecs.push_back(mk(1, 3'd0, 5'd5, 1, 64'hF2,                 1, 5'd2,  1, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'hF3,                 1, 5'd3,  1, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'hF4,                 1, 5'd4,  1, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 1, 64'hF5,                 1, 5'd5,  1, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 5'd0, 0, 64'h0,                  0, 5'd0,  0, 0, 1, 1));

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk_reset(-1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset in the middle of an LMUL2 group (regs 4,5): partial group must be discarded
    apply(mk(1, 3'd1, 5'd2, 0, 64'h0,    0, 5'd0, 0, 0, 0, 1), 100);
    apply(mk(0, 3'd0, 5'd0, 1, 64'h4444, 1, 5'd4, 0, 0, 0, 1), 101);
    rst = 1'b0;
    #1;
    chk_reset(102);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    apply(mk(0, 3'd0, 5'd0, 1, 64'h5555, 0, 5'd0, 0, 1, 1, 1), 103);
    apply(mk(0, 3'd0, 5'd0, 1, 64'h5556, 0, 5'd0, 0, 1, 1, 1), 104);
    apply(mk(0, 3'd0, 5'd0, 0, 64'h0,    0, 5'd0, 0, 0, 1, 1), 105);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
